// File: rtl/layer1_fm_writer_if.sv
// layer1_fm_writer_if: pooled-beat input plus framed write and readout handshake of the layer-1 feature-map store.
interface layer1_fm_writer_if;
    logic         pool_valid;
    logic         pool_ready;
    logic [255:0] pool_data;
    logic         fm_wea;
    logic         pre_vsync;
    logic         pre_href;
    logic [255:0] pre_data;
    logic         save_fm_acmp;
    logic         start_output;
    logic         end_output;
    modport master (
        input  pool_valid, pool_data, save_fm_acmp, end_output,
        output pool_ready, fm_wea, pre_vsync, pre_href, pre_data, start_output
    );
    modport slave (
        output pool_valid, pool_data, save_fm_acmp, end_output,
        input  pool_ready, fm_wea, pre_vsync, pre_href, pre_data, start_output
    );
endinterface

// File: rtl/layer1_fm_writer.sv
// layer1_fm_writer: turns pooled pixel beats into the feature-map store's framed write stream and sequences save/readout.
// Defining LAYER1_FMW_TIMEOUT_EN adds a watchdog on the save-ack and readout waits.
module layer1_fm_writer #(
    parameter int FM_WIDTH  = 4,
    parameter int FM_HEIGHT = 4,
    parameter int VS_CYC    = 2,
    parameter int HGAP      = 1,
    parameter int TO_CYC    = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    output logic busy,
    output logic frame_err,
    layer1_fm_writer_if.master bus
);
    localparam int SMAX = VS_CYC > HGAP ? VS_CYC : HGAP;
    localparam int CMAX = SMAX > TO_CYC ? SMAX : TO_CYC;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam int XW   = $clog2(FM_WIDTH) + 1;
    localparam int YW   = $clog2(FM_HEIGHT) + 1;
    typedef enum logic [2:0] {IDLE, VS, STREAM, GAP, WAIT_ACK, START, OUT} state_t;
    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          href_q;
    logic [255:0]  data_q;
    logic          xfer, row_end, last, accept, early_ack, to_hit;
    assign xfer      = state == STREAM && bus.pool_valid;
    assign row_end   = col == XW'(FM_WIDTH - 1);
    assign last      = row_end && row == YW'(FM_HEIGHT - 1);
    assign accept    = state == IDLE && frame_start;
    assign early_ack = bus.save_fm_acmp && (state == VS || state == STREAM || state == GAP);
`ifdef LAYER1_FMW_TIMEOUT_EN
    // OUT keeps counting from its START cycle, so the limit covers the whole readout wait
    assign to_hit = (state == WAIT_ACK || state == OUT) && cnt >= CW'(TO_CYC - 1);
`else
    assign to_hit = 1'b0;
`endif
    always_comb begin
        state_nx         = state;
        bus.pool_ready   = state == STREAM;
        bus.fm_wea       = state == VS || state == STREAM || state == GAP || href_q;
        bus.pre_vsync    = state == VS;
        bus.pre_href     = href_q;
        bus.pre_data     = data_q;
        bus.start_output = state == START;
        busy             = state != IDLE;
        case (state)
            IDLE:     state_nx = frame_start ? VS : IDLE;
            VS:       state_nx = cnt == CW'(VS_CYC - 1) ? STREAM : VS;
            STREAM:   state_nx = !(xfer && row_end) ? STREAM : last ? WAIT_ACK : GAP;
            GAP:      state_nx = cnt == CW'(HGAP - 1) ? STREAM : GAP;
            WAIT_ACK: state_nx = bus.save_fm_acmp ? START : to_hit ? IDLE : WAIT_ACK;
            START:    state_nx = OUT;
            OUT:      state_nx = bus.end_output || to_hit ? IDLE : OUT;
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            col       <= '0;
            row       <= '0;
            href_q    <= 1'b0;
            data_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= (state_nx != state && state != START) ? '0 : cnt + 1'b1;
            href_q    <= xfer;
            data_q    <= xfer ? bus.pool_data : data_q;
            col       <= accept ? '0 : xfer ? (row_end ? '0 : col + 1'b1) : col;
            row       <= accept ? '0 : (xfer && row_end) ? row + 1'b1 : row;
            frame_err <= accept ? 1'b0 : frame_err | early_ack | to_hit;
        end
    end
endmodule
